// File: rtl/conv_kernel_pos.sv
// Walks a WxH frame raster and tags each accepted pixel beat with its centre row/col and border flags.
// Latency 1 beat-to-output; in_rdy_o follows the single output register (no bubble under continuous out_rdy_i).
package conv_pkg;
   typedef struct packed {
      logic n1;
      logic n2;
      logic s1;
      logic s2;
      logic e1;
      logic e2;
      logic w1;
      logic w2;
   } kernel_pos_t;
endpackage

module conv_kernel_pos #(
   parameter int DIM_W = 12
) (
   input  logic                 clk,
   input  logic                 arst,
   input  logic                 start_i,
   input  logic [DIM_W-1:0]     cfg_width_i,
   input  logic [DIM_W-1:0]     cfg_height_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   input  logic                 in_vld_i,
   output logic                 in_rdy_o,
   output logic                 out_vld_o,
   input  logic                 out_rdy_i,
   output conv_pkg::kernel_pos_t out_kernel_pos_o,
   output logic [DIM_W-1:0]     out_row_o,
   output logic [DIM_W-1:0]     out_col_o
);

   localparam logic [DIM_W-1:0] ONE  = DIM_W'(1);
   localparam logic [DIM_W-1:0] TWO  = DIM_W'(2);
   localparam logic [DIM_W-1:0] ZERO = '0;

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_start_ok;
   logic                  w_cfg_err;
   logic                  w_accept;
   logic                  w_last_col;
   logic                  w_last;
   logic [DIM_W-1:0]      r_width;
   logic [DIM_W-1:0]      r_height;
   logic [DIM_W-1:0]      r_row;
   logic [DIM_W-1:0]      r_col;
   logic                  r_out_vld;
   logic                  r_done;
   logic                  r_err;
   conv_pkg::kernel_pos_t r_kpos;
   conv_pkg::kernel_pos_t w_kpos;
   logic [DIM_W-1:0]      r_out_row;
   logic [DIM_W-1:0]      r_out_col;

   assign in_rdy_o   = (r_state == ST_RUN) & (~r_out_vld | out_rdy_i);
   assign w_accept   = in_vld_i & in_rdy_o;
   assign w_last_col = (r_col == r_width - ONE);
   assign w_last     = w_last_col & (r_row == r_height - ONE);

   // The >= TWO guards stop W-2/H-2 from wrapping into a false match on tiny frames.
   always_comb begin
      w_kpos    = '0;
      w_kpos.n2 = (r_row == ZERO);
      w_kpos.n1 = (r_row == ONE);
      w_kpos.s2 = (r_row == r_height - ONE);
      w_kpos.s1 = (r_height >= TWO) && (r_row == r_height - TWO);
      w_kpos.w2 = (r_col == ZERO);
      w_kpos.w1 = (r_col == ONE);
      w_kpos.e2 = (r_col == r_width - ONE);
      w_kpos.e1 = (r_width >= TWO) && (r_col == r_width - TWO);
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start_ok  = 1'b0;
      w_cfg_err   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start_i) begin
               if ((cfg_width_i == ZERO) || (cfg_height_i == ZERO)) begin
                  w_cfg_err = 1'b1;
               end else begin
                  w_start_ok  = 1'b1;
                  w_state_nxt = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (w_accept && w_last) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_state  <= ST_IDLE;
         r_width  <= '0;
         r_height <= '0;
         r_row    <= '0;
         r_col    <= '0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= w_accept & w_last;
         r_err   <= w_cfg_err;
         if (w_start_ok) begin
            r_width  <= cfg_width_i;
            r_height <= cfg_height_i;
            r_row    <= '0;
            r_col    <= '0;
         end else if (w_accept) begin
            if (w_last_col) begin
               r_col <= '0;
               r_row <= r_row + ONE;
            end else begin
               r_col <= r_col + ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_out_vld <= 1'b0;
         r_kpos    <= '0;
         r_out_row <= '0;
         r_out_col <= '0;
      end else if (w_accept) begin
         r_out_vld <= 1'b1;
         r_kpos    <= w_kpos;
         r_out_row <= r_row;
         r_out_col <= r_col;
      end else if (out_rdy_i) begin
         r_out_vld <= 1'b0;
      end
   end

   assign busy_o           = (r_state == ST_RUN);
   assign done_o           = r_done;
   assign err_o            = r_err;
   assign out_vld_o        = r_out_vld;
   assign out_kernel_pos_o = r_kpos;
   assign out_row_o        = r_out_row;
   assign out_col_o        = r_out_col;

endmodule

// File: tb/tb_conv_kernel_pos.sv
// Bench for conv_kernel_pos: cycle model plus beat scoreboard, driven by directed frames.
module tb_conv_kernel_pos;

   logic                  clk = 1'b0;
   logic                  arst = 1'b1;
   logic                  start_i = 1'b0;
   logic [11:0]           cfg_w = '0;
   logic [11:0]           cfg_h = '0;
   logic                  in_vld_i = 1'b0;
   logic                  out_rdy_i = 1'b0;
   logic                  busy_o, done_o, err_o, in_rdy_o, out_vld_o;
   conv_pkg::kernel_pos_t kpos;
   logic [11:0]           row_o, col_o;

   int          n_vec = 0;
   int          n_err = 0;
   int          n_done = 0;
   int          n_errp = 0;
   bit          m_run = 0, m_ovld = 0, m_done = 0, m_err = 0, p_stall = 0;
   int          m_W = 0, m_H = 0, m_r = 0, m_c = 0, m_acc_cnt = 0;
   logic [31:0] p_hold = '0;
   logic [31:0] sb[$];
   logic [31:0] log_q[$];

   conv_kernel_pos #(.DIM_W(12)) dut (
      .clk(clk), .arst(arst), .start_i(start_i),
      .cfg_width_i(cfg_w), .cfg_height_i(cfg_h),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .in_vld_i(in_vld_i), .in_rdy_o(in_rdy_o),
      .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i),
      .out_kernel_pos_o(kpos), .out_row_o(row_o), .out_col_o(col_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // flags packed {n1,n2,s1,s2,e1,e2,w1,w2}, then row, then col
   function automatic logic [31:0] exp_beat(input int r, input int c, input int w, input int h);
      logic [7:0]  f;
      logic [11:0] rr, cc;
      f[7] = (r == 1);
      f[6] = (r == 0);
      f[5] = (h >= 2) && (r == h - 2);
      f[4] = (r == h - 1);
      f[3] = (w >= 2) && (c == w - 2);
      f[2] = (c == w - 1);
      f[1] = (c == 1);
      f[0] = (c == 0);
      rr = r[11:0];
      cc = c[11:0];
      return {f, rr, cc};
   endfunction

   always @(negedge clk) begin
      logic [31:0] obs;
      logic [31:0] e;
      bit          acc;
      bit          m_rdy;
      obs = {kpos, row_o, col_o};
      if (arst) begin
         m_run = 0; m_ovld = 0; m_done = 0; m_err = 0;
         m_r = 0; m_c = 0; p_stall = 0;
         sb.delete();
      end else begin
         m_rdy = m_run & (~m_ovld | out_rdy_i);
         chk("busy", {31'd0, busy_o}, {31'd0, m_run});
         chk("in_rdy", {31'd0, in_rdy_o}, {31'd0, m_rdy});
         chk("out_vld", {31'd0, out_vld_o}, {31'd0, m_ovld});
         chk("done", {31'd0, done_o}, {31'd0, m_done});
         chk("err", {31'd0, err_o}, {31'd0, m_err});
         if (done_o) n_done++;
         if (err_o) n_errp++;
         if (p_stall) chk("stall_hold", obs, p_hold);
         if (out_vld_o && out_rdy_i) begin
            chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("beat", obs, e);
            end
            log_q.push_back(obs);
         end
         p_stall = out_vld_o & ~out_rdy_i;
         p_hold  = obs;
         acc     = in_vld_i & m_rdy;
         m_done  = acc && (m_r == m_H - 1) && (m_c == m_W - 1);
         m_err   = !m_run && start_i && (cfg_w == 0 || cfg_h == 0);
         m_ovld  = acc | (m_ovld & ~out_rdy_i);
         if (acc) begin
            sb.push_back(exp_beat(m_r, m_c, m_W, m_H));
            m_acc_cnt++;
            if (m_c == m_W - 1) begin
               m_c = 0;
               m_r++;
            end else begin
               m_c++;
            end
         end
         if (!m_run && start_i && cfg_w != 0 && cfg_h != 0) begin
            m_run = 1; m_W = int'(cfg_w); m_H = int'(cfg_h); m_r = 0; m_c = 0;
         end else if (m_done) begin
            m_run = 0;
         end
      end
   end

   // rdy_mode: 0 always ready, 1 toggle every cycle, 2 never ready
   task automatic run_frame(input int w, input int h, input int rdy_mode,
                            input int restart_at, input int stop_after, output int base);
      int cyc;
      @(posedge clk); #1;
      base      = log_q.size() + sb.size();
      m_acc_cnt = 0;
      start_i   = 1'b1;
      cfg_w     = w[11:0];
      cfg_h     = h[11:0];
      @(posedge clk); #1;
      start_i   = 1'b0;
      cfg_w     = 12'd7;
      cfg_h     = 12'd7;
      in_vld_i  = 1'b1;
      out_rdy_i = (rdy_mode != 2);
      cyc = 0;
      while (busy_o && cyc < 400) begin
         if (stop_after > 0 && m_acc_cnt >= stop_after) break;
         if (rdy_mode == 1) out_rdy_i = ~out_rdy_i;
         start_i = (cyc == restart_at);
         @(posedge clk); #1;
         cyc++;
      end
      start_i  = 1'b0;
      in_vld_i = 1'b0;
      chk("frame_timeout", {31'd0, cyc < 400}, 32'd1);
   endtask

   task automatic drain();
      int cyc;
      out_rdy_i = 1'b1;
      in_vld_i  = 1'b0;
      cyc = 0;
      while ((out_vld_o || sb.size() != 0) && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("drain_timeout", {31'd0, cyc < 50}, 32'd1);
   endtask

   initial begin
      int b0, b1, b2, b3, b4;
      #2;
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_in_rdy", {31'd0, in_rdy_o}, 32'd0);
      chk("rst_out_vld", {31'd0, out_vld_o}, 32'd0);
      chk("rst_done_err", {30'd0, done_o, err_o}, 32'd0);
      chk("rst_fields", {kpos, row_o, col_o}, 32'd0);
      repeat (2) @(posedge clk);
      #1 arst = 1'b0;

      // zero width: error pulse, stay idle
      @(posedge clk); #1;
      start_i = 1'b1; cfg_w = 12'd0; cfg_h = 12'd3;
      @(posedge clk); #1;
      start_i = 1'b0;
      chk("err_pulse", {31'd0, err_o}, 32'd1);
      chk("err_busy", {31'd0, busy_o}, 32'd0);
      chk("err_in_rdy", {31'd0, in_rdy_o}, 32'd0);
      @(posedge clk); #1;
      chk("err_one_cycle", {31'd0, err_o}, 32'd0);
      chk("err_still_idle", {31'd0, busy_o}, 32'd0);

      run_frame(5, 4, 0, -1, 0, b0);
      drain();
      chk("f5x4_count", log_q.size() - b0, 32'd20);
      chk("f5x4_b0", {24'd0, log_q[b0][31:24]}, 32'h41);
      chk("f5x4_b1", {24'd0, log_q[b0+1][31:24]}, 32'h42);
      chk("f5x4_b4", {24'd0, log_q[b0+4][31:24]}, 32'h44);
      chk("f5x4_b13", log_q[b0+13], {8'h28, 12'd2, 12'd3});
      chk("f5x4_b19", log_q[b0+19], {8'h14, 12'd3, 12'd4});
      chk("f5x4_done", n_done, 32'd1);

      // 1x1 frame left pending at output while the 3x3 stalled frame starts
      run_frame(1, 1, 2, -1, 0, b1);
      chk("pending_vld", {31'd0, out_vld_o}, 32'd1);
      run_frame(3, 3, 1, -1, 0, b2);
      drain();
      chk("f1x1_flags", {24'd0, log_q[b1][31:24]}, 32'h55);
      chk("f3x3_count", log_q.size() - b2, 32'd9);
      chk("f3x3_last", log_q[b2+8][23:0], {12'd2, 12'd2});
      chk("f3x3_done", n_done, 32'd3);

      // restart attempt with cfg 7x7 mid-frame is ignored
      run_frame(3, 2, 0, 2, 0, b3);
      drain();
      chk("f3x2_count", log_q.size() - b3, 32'd6);
      chk("f3x2_done", n_done, 32'd4);

      // abort after 7 beats
      run_frame(4, 4, 0, -1, 7, b4);
      arst = 1'b1;
      #1;
      chk("abort_acc", m_acc_cnt, 32'd7);
      chk("abort_vld", {31'd0, out_vld_o}, 32'd0);
      chk("abort_busy", {31'd0, busy_o}, 32'd0);
      chk("abort_in_rdy", {31'd0, in_rdy_o}, 32'd0);
      repeat (2) @(posedge clk);
      #1 arst = 1'b0;
      run_frame(2, 2, 0, -1, 0, b4);
      drain();
      chk("f2x2_count", log_q.size() - b4, 32'd4);
      chk("f2x2_b0", {24'd0, log_q[b4][31:24]}, 32'h69);
      chk("f2x2_done", n_done, 32'd5);
      chk("err_total", n_errp, 32'd1);
      chk("sb_empty", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
